// File: rtl/axi_cmd_master.sv
// rtl/axi_cmd_master.sv - single-outstanding AXI4 master fed by a command/data-stream interface
// Commands are legality-checked against the downstream slave's rules before any bus activity.
module axi_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [1:0]              done_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int SMAX = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t          state;
  logic [7:0]      beat_cnt;
  logic [1:0]      resp_acc;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [12:0]     burst_end;
  logic            cmd_illegal;
  logic            r_hs;
  logic            r_final_exp;
  logic [1:0]      r_merge;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    align_mask  = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    burst_end   = {1'b0, cmd_addr[11:0]} + ((13'(cmd_len) + 13'd1) << cmd_size);
    cmd_illegal = (cmd_burst == 2'b11) ||
                  (cmd_size > 3'(SMAX)) ||
                  (|(cmd_addr & align_mask)) ||
                  ((cmd_burst == 2'b10) && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  (burst_end > 13'd4096);
  end

  // An RLAST that disagrees with the expected final beat is a protocol error merged as SLVERR.
  always_comb begin
    r_hs        = (state == S_R) && RVALID && rd_ready;
    r_final_exp = (beat_cnt == ARLEN);
    r_merge     = resp_max(resp_acc, RRESP);
    if (RLAST != r_final_exp) r_merge = resp_max(r_merge, 2'b10);
  end

  assign cmd_ready = (state == S_IDLE) && !ARESET;
  assign WVALID    = (state == S_W) && wd_valid;
  assign wd_ready  = (state == S_W) && WREADY;
  assign WDATA     = wd_data;
  assign WSTRB     = wd_strb;
  assign WLAST     = (state == S_W) && (beat_cnt == 8'd0);
  assign rd_valid  = (state == S_R) && RVALID;
  assign RREADY    = (state == S_R) && rd_ready;
  assign rd_data   = RDATA;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      AWADDR     <= '0;
      AWLEN      <= '0;
      AWSIZE     <= '0;
      AWBURST    <= '0;
      AWVALID    <= 1'b0;
      ARADDR     <= '0;
      ARLEN      <= '0;
      ARSIZE     <= '0;
      ARBURST    <= '0;
      ARVALID    <= 1'b0;
      BREADY     <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= 2'b00;
      beat_cnt   <= 8'd0;
      resp_acc   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          resp_acc <= 2'b00;
          if (cmd_illegal) begin
            done_resp  <= 2'b10;
            done_valid <= 1'b1;
            state      <= S_DONE;
          end else if (cmd_write) begin
            AWADDR  <= cmd_addr;
            AWLEN   <= cmd_len;
            AWSIZE  <= cmd_size;
            AWBURST <= cmd_burst;
            AWVALID <= 1'b1;
            state   <= S_AW;
          end else begin
            ARADDR  <= cmd_addr;
            ARLEN   <= cmd_len;
            ARSIZE  <= cmd_size;
            ARBURST <= cmd_burst;
            ARVALID <= 1'b1;
            state   <= S_AR;
          end
        end
        S_AW: if (AWREADY) begin
          AWVALID  <= 1'b0;
          beat_cnt <= AWLEN;
          state    <= S_W;
        end
        S_W: if (WVALID && WREADY) begin
          if (beat_cnt == 8'd0) begin
            BREADY <= 1'b1;
            state  <= S_B;
          end else begin
            beat_cnt <= beat_cnt - 8'd1;
          end
        end
        S_B: if (BVALID) begin
          BREADY     <= 1'b0;
          done_resp  <= BRESP;
          done_valid <= 1'b1;
          state      <= S_DONE;
        end
        S_AR: if (ARREADY) begin
          ARVALID  <= 1'b0;
          beat_cnt <= 8'd0;
          state    <= S_R;
        end
        S_R: if (r_hs) begin
          resp_acc <= r_merge;
          beat_cnt <= beat_cnt + 8'd1;
          // A missing RLAST still terminates the burst after the expected beat count.
          if (RLAST || r_final_exp) begin
            done_resp  <= r_merge;
            done_valid <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: if (done_ready) begin
          done_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// tb/tb_axi_cmd_master.sv - directed self-checking bench for axi_cmd_master with a behavioural AXI4 slave
module tb_axi_cmd_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_ready;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done_valid, done_ready;
  logic [1:0]  done_resp;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [3:0]  WSTRB;

  axi_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave configuration and observation
  bit   [31:0] mem [1024];
  int          aw_wait_cfg = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
  int          early_last_cfg = -1;
  bit          rd_toggle = 1'b0;
  int          aw_stall = 0, w_i = 0, r_i = 0;
  bit          w_act = 1'b0, b_pend = 1'b0, r_act = 1'b0, prev_awv = 1'b0;
  logic [31:0] w_addr, r_addr, prev_awaddr;
  logic [7:0]  w_len, r_len;
  logic [1:0]  w_burst, r_burst, aw_burst_seen;
  int          aw_cycles = 0, ar_cycles = 0, aw_changes = 0, w_beats = 0, wlast_cnt = 0, wlast_beat = -1, wd_used = 0;
  logic [31:0] rd_log [$];

  function automatic int widx(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input int i);
    int span, base, addr;
    span = (int'(l) + 1) * 4;
    if (b == 2'b10) begin
      base = (int'(a) / span) * span;
      addr = base + ((int'(a) - base + i * 4) % span);
    end else begin
      addr = int'(a) + i * 4;
    end
    return (addr >> 2) & 1023;
  endfunction

  // Slave outputs change on the falling edge; handshakes for the coming rising edge are taken 1ns later.
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; rd_ready = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        w_act = 0; b_pend = 0; r_act = 0; aw_stall = 0; prev_awv = 0;
      end else begin
        AWREADY  = AWVALID && (aw_stall >= aw_wait_cfg);
        WREADY   = w_act;
        BVALID   = b_pend;
        BRESP    = bresp_cfg;
        ARREADY  = ARVALID;
        RVALID   = r_act;
        RDATA    = r_act ? mem[widx(r_addr, r_len, r_burst, r_i)] : 32'h0;
        RRESP    = r_act ? rresp_cfg[r_i & 3] : 2'b00;
        RLAST    = r_act && ((early_last_cfg >= 0) ? (r_i == early_last_cfg) : (r_i == int'(r_len)));
        rd_ready = rd_toggle ? ~rd_ready : 1'b1;
        #1;
        if (AWVALID) begin
          aw_cycles++;
          if (prev_awv && AWADDR != prev_awaddr) aw_changes++;
        end
        prev_awv    = AWVALID && !AWREADY;
        prev_awaddr = AWADDR;
        if (ARVALID) ar_cycles++;
        if (wd_valid && wd_ready) wd_used++;
        if (AWVALID && AWREADY) begin
          w_act = 1; w_addr = AWADDR; w_len = AWLEN; w_burst = AWBURST; w_i = 0;
          aw_burst_seen = AWBURST; aw_stall = 0;
        end else if (AWVALID) begin
          aw_stall++;
        end
        if (WVALID && WREADY) begin
          mem[widx(w_addr, w_len, w_burst, w_i)] = WDATA;
          w_beats++;
          if (WLAST) begin wlast_cnt++; wlast_beat = w_i; end
          if (w_i == int'(w_len)) begin w_act = 0; b_pend = 1; end
          w_i++;
        end
        if (BVALID && BREADY) b_pend = 0;
        if (ARVALID && ARREADY) begin
          r_act = 1; r_addr = ARADDR; r_len = ARLEN; r_burst = ARBURST; r_i = 0;
        end
        if (rd_valid && rd_ready) begin
          rd_log.push_back(rd_data);
          if (RLAST) r_act = 0;
          r_i++;
        end
      end
    end
  end

  // Returns 1ns after the falling edge of the cycle following acceptance.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    #1;
    while (!cmd_ready && n < 50) begin @(negedge ACLK); #1; n++; end
    check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    @(negedge ACLK);
    cmd_valid = 0;
    #1;
  endtask

  task automatic send_wd(input int n, input logic [31:0] base, input bit toggle);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 300) begin
      @(negedge ACLK);
      wd_valid = toggle ? cyc[0] : 1'b1;
      wd_data  = base + 32'(i);
      wd_strb  = 4'hF;
      #1;
      if (wd_valid && wd_ready) i++;
      cyc++;
    end
    check("wd_all_sent", 32'(i), 32'(n));
    @(negedge ACLK);
    wd_valid = 0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp);
    int n = 0;
    bit seen = 0;
    logic [1:0] got = 2'b00;
    while (!seen && n < 400) begin
      if (done_valid) begin seen = 1; got = done_resp; end
      else begin @(negedge ACLK); #1; n++; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_resp"}, 32'(got), 32'(exp));
    @(negedge ACLK);
    #1;
  endtask

  task automatic check_rd(input string tag, input int n, input logic [31:0] base);
    check({tag, "_rd_count"}, 32'(rd_log.size()), 32'(n));
    for (int i = 0; i < n && i < rd_log.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_log[i], base + 32'(i));
  endtask

  logic [31:0] il_addr  [4] = '{32'h002, 32'h010, 32'hFF8, 32'h000};
  logic [7:0]  il_len   [4] = '{8'd0, 8'd0, 8'd3, 8'd2};
  logic [1:0]  il_burst [4] = '{2'b01, 2'b11, 2'b01, 2'b10};

  initial begin
    int a0, r0, u0, wb0, wl0, n;
    bit hs;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; done_ready = 1;
    #1 ARESET = 1;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_awvalid", 32'(AWVALID), 0);
    check("rst_arvalid", 32'(ARVALID), 0);
    check("rst_bready", 32'(BREADY), 0);
    check("rst_done_valid", 32'(done_valid), 0);
    check("rst_done_resp", 32'(done_resp), 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_araddr", ARADDR, 0);
    @(negedge ACLK); @(negedge ACLK); #3 ARESET = 0;
    @(negedge ACLK); #1;
    check("release_cmd_ready", 32'(cmd_ready), 1);

    wb0 = w_beats; wl0 = wlast_cnt;
    send_cmd(1, 32'h10, 8'd3, 3'd2, 2'b01);
    check("wr1_awvalid_n1", 32'(AWVALID), 1);
    check("wr1_awaddr", AWADDR, 32'h10);
    check("wr1_busy_cmd_ready", 32'(cmd_ready), 0);
    fork
      send_wd(4, 32'hA0, 1'b0);
      wait_done("wr1", 2'b00);
    join
    check("wr1_beats", 32'(w_beats - wb0), 4);
    check("wr1_wlast_count", 32'(wlast_cnt - wl0), 1);
    check("wr1_wlast_beat", 32'(wlast_beat), 3);

    rd_log.delete();
    send_cmd(0, 32'h10, 8'd3, 3'd2, 2'b01);
    check("rd1_arvalid_n1", 32'(ARVALID), 1);
    wait_done("rd1", 2'b00);
    check_rd("rd1", 4, 32'hA0);

    send_cmd(1, 32'h0C, 8'd3, 3'd2, 2'b10);
    check("wrap_awburst", 32'(AWBURST), 32'h2);
    fork
      send_wd(4, 32'hB0, 1'b0);
      wait_done("wrap_wr", 2'b00);
    join
    check("wrap_slave_burst", 32'(aw_burst_seen), 32'h2);
    rd_log.delete();
    send_cmd(0, 32'h0C, 8'd3, 3'd2, 2'b10);
    wait_done("wrap_rd", 2'b00);
    check_rd("wrap_rd", 4, 32'hB0);

    for (int i = 0; i < 4; i++) begin
      a0 = aw_cycles; r0 = ar_cycles; u0 = wd_used;
      wd_valid = 1; wd_data = 32'hEE; wd_strb = 4'hF;
      send_cmd(i[0], il_addr[i], il_len[i], 3'd2, il_burst[i]);
      check($sformatf("ill%0d_done_n1", i), 32'(done_valid), 1);
      check($sformatf("ill%0d_resp_n1", i), 32'(done_resp), 32'h2);
      wait_done($sformatf("ill%0d", i), 2'b10);
      wd_valid = 0;
      check($sformatf("ill%0d_no_aw", i), 32'(aw_cycles - a0), 0);
      check($sformatf("ill%0d_no_ar", i), 32'(ar_cycles - r0), 0);
      check($sformatf("ill%0d_no_wd", i), 32'(wd_used - u0), 0);
    end

    r0 = ar_cycles; rd_log.delete();
    send_cmd(0, 32'hFF0, 8'd3, 3'd2, 2'b01);
    wait_done("edge4k", 2'b00);
    check("edge4k_ar_issued", 32'(ar_cycles > r0), 1);
    check("edge4k_rd_count", 32'(rd_log.size()), 4);

    rresp_cfg = '{2'b00, 2'b10, 2'b00, 2'b00};
    rd_log.delete();
    send_cmd(0, 32'h10, 8'd3, 3'd2, 2'b01);
    wait_done("rresp", 2'b10);
    check_rd("rresp", 4, 32'hA0);
    rresp_cfg = '{2'b00, 2'b00, 2'b00, 2'b00};

    early_last_cfg = 1;
    rd_log.delete();
    send_cmd(0, 32'h10, 8'd3, 3'd2, 2'b01);
    wait_done("early", 2'b10);
    check_rd("early", 2, 32'hA0);
    check("early_back_idle", 32'(cmd_ready), 1);
    early_last_cfg = -1;

    aw_wait_cfg = 5; bresp_cfg = 2'b01;
    a0 = aw_cycles; n = aw_changes; wb0 = w_beats; wl0 = wlast_cnt;
    send_cmd(1, 32'h40, 8'd3, 3'd2, 2'b01);
    fork
      send_wd(4, 32'hC0, 1'b1);
      wait_done("bp_wr", 2'b01);
    join
    check("bp_aw_cycles", 32'(aw_cycles - a0), 6);
    check("bp_aw_stable", 32'(aw_changes - n), 0);
    check("bp_beats", 32'(w_beats - wb0), 4);
    check("bp_wlast_count", 32'(wlast_cnt - wl0), 1);
    aw_wait_cfg = 0; bresp_cfg = 2'b00; rd_toggle = 1;
    rd_log.delete();
    send_cmd(0, 32'h40, 8'd3, 3'd2, 2'b01);
    wait_done("bp_rd", 2'b00);
    check_rd("bp_rd", 4, 32'hC0);
    rd_toggle = 0;

    send_cmd(1, 32'h80, 8'd3, 3'd2, 2'b01);
    n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge ACLK);
      wd_valid = 1; wd_data = 32'hD0; wd_strb = 4'hF;
      #1;
      hs = wd_ready;
      n++;
    end
    check("mid_beat1_seen", 32'(hs), 1);
    @(posedge ACLK); #1;
    check("mid_wvalid_before", 32'(WVALID), 1);
    #1 ARESET = 1;
    #1;
    check("mid_wvalid_drop", 32'(WVALID), 0);
    check("mid_awvalid_drop", 32'(AWVALID), 0);
    check("mid_bready_drop", 32'(BREADY), 0);
    check("mid_cmd_ready_rst", 32'(cmd_ready), 0);
    check("mid_done_valid", 32'(done_valid), 0);
    wd_valid = 0;
    @(negedge ACLK); @(negedge ACLK); #3 ARESET = 0;
    @(negedge ACLK); #1;
    check("mid_release_cmd_ready", 32'(cmd_ready), 1);
    rd_log.delete();
    send_cmd(0, 32'h10, 8'd3, 3'd2, 2'b01);
    wait_done("post_rst_rd", 2'b00);
    check_rd("post_rst_rd", 4, 32'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
